id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline. Captures decoded operands and control from ID and presents them to EX.
- Its ex_rs1/ex_rs2 outputs feed the forwarding unit's rs1_id_ex/rs2_id_ex inputs. Its ex_rd/ex_reg_write become the next cycle's EX/MEM destination.
- Owns load-use hazard detection, bubble insertion, branch flush and downstream hold.

Parameters:
- XLEN, 32, datapath width.
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..7). Covers slower data memory.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1 each  decoded control.
- id_alu_op  in  4  ALU operation.
- flush_ex  in  1  taken branch/jump resolved in EX; squash the instruction entering EX.
- ex_stall  in  1  downstream hold (multi-cycle MEM); freeze this register.
- ex_valid  out  1  EX instruction is real.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1 each.
- ex_alu_op  out  4.
- stall_id  out  1  combinational; hold PC and IF/ID this cycle.
- perf_bubbles, perf_flushes  out  32  performance counters (see Optional Feature).

Behaviour:
- Reset:
  - Asynchronous.
  - All ex_* outputs = 0 (ex_valid=0).
  - State = RUN, bubble counter = 0, perf counters = 0.
- Hazard:
  - hz = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
  - Compare both sources regardless of instruction format; over-stall is accepted.
- States:
  - RUN: normal operation.
  - BUBBLE: counter cnt (3 bits) holds remaining bubbles.
- stall_id = ex_stall | (RUN & hz & ~flush_ex) | (BUBBLE & ~flush_ex).
- Per rising edge, first matching rule applies:
  1. ex_stall=1: hold all registers, state and cnt. flush_ex is ignored that cycle; the EX stage must keep it asserted until the hold releases.
  2. flush_ex=1: load a bubble (all ex_* = 0). State -> RUN, cnt -> 0.
  3. RUN & hz: load a bubble. If LOAD_USE_STALLS>1: state -> BUBBLE, cnt = LOAD_USE_STALLS-1. Otherwise stay RUN.
  4. BUBBLE: load a bubble. If cnt==1 -> RUN, else cnt -= 1.
  5. Otherwise: capture all id_* into ex_*; ex_valid = id_valid.
- Bubble definition:
  - Every ex_* field is zeroed, including data, so bubbles are deterministic.
  - Forwarding therefore never matches (rd=0, reg_write=0).
- Latency: 1 cycle ID->EX in RUN. A load-use pair separates by exactly LOAD_USE_STALLS bubbles.
- ID instruction with id_valid=0 is captured with ex_valid=0. Its control bits pass through unmodified; EX must gate on ex_valid.
- Back-to-back loads that each cause a hazard:
  - The second hazard is evaluated against the second load once it reaches EX.
  - cnt never wraps: at most LOAD_USE_STALLS bubbles per hazard.
- Reset asserted mid-BUBBLE or mid-hold returns immediately to reset values. stall_id drops to 0 while rst=1.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- Defined:
  - perf_bubbles increments on each edge where a hazard bubble is loaded (rules 3 and 4).
  - perf_flushes increments on each edge where rule 2 fires.
  - Both counters are 32-bit, wrap modulo 2^32 and clear on rst.
- Undefined: both ports tied to 0; no counter flops are synthesized.

Test Plan:
- Reset: rst=1 mid-stream with state BUBBLE -> all ex_* = 0, stall_id=0. After release, first id instruction (pc=0x100) appears on ex_pc on the 1st edge.
- Load-use, LOAD_USE_STALLS=1: lw x5 in EX (ex_mem_read=1, ex_rd=5) with id_rs2=5 -> stall_id=1 for 1 cycle, one bubble (ex_valid=0, ex_rd=0). Dependent instruction enters EX on the next edge.
- Load-use, LOAD_USE_STALLS=3: same stimulus -> stall_id high 3 consecutive cycles, 3 bubbles. With IDEX_PERF_CNT_EN defined, perf_bubbles=3.
- ex_rd=0 load with id_rs1=0 -> no stall; instruction passes in 1 cycle.
- Flush priority: flush_ex=1 in the same cycle as BUBBLE state (cnt=2) -> bubble loaded, state RUN, stall_id=0 that cycle. perf_flushes=1 when the macro is defined.
- Hold: ex_stall=1 for 4 cycles with a valid add in EX -> ex_* unchanged, stall_id=1 throughout, flush_ex asserted during the hold ignored. On release, the next id instruction is captured.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, branch flush and hold.
// Optional performance counters are enabled by defining IDEX_PERF_CNT_EN.
module id_ex_stage_reg #(
  parameter int XLEN            = 32,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic [3:0]      id_alu_op,
  input  logic            flush_ex,
  input  logic            ex_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic [3:0]      ex_alu_op,
  output logic            stall_id,
  output logic [31:0]     perf_bubbles,
  output logic [31:0]     perf_flushes
);

  typedef enum logic {RUN, BUBBLE} state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic [3:0]      alu_op;
  } idex_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       hz, load_bub, capture;
  idex_t      id_bundle, ex_q;

  assign id_bundle = '{valid: id_valid, pc: id_pc, rs1_data: id_rs1_data,
                       rs2_data: id_rs2_data, imm: id_imm, rs1: id_rs1, rs2: id_rs2,
                       rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read,
                       mem_write: id_mem_write, mem_to_reg: id_mem_to_reg,
                       alu_src: id_alu_src, branch: id_branch, alu_op: id_alu_op};

  // Both sources are compared regardless of format; an occasional over-stall is harmless.
  assign hz = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
              ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  assign stall_id = ~rst & (ex_stall | ((state == RUN) & hz & ~flush_ex) |
                            ((state == BUBBLE) & ~flush_ex));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_bub  = 1'b0;
    capture   = 1'b0;
    if (ex_stall) begin
      // Full freeze: a flush presented during a hold is re-asserted by EX afterwards.
    end else if (flush_ex) begin
      load_bub  = 1'b1;
      state_nxt = RUN;
      cnt_nxt   = 3'd0;
    end else if ((state == RUN) && hz) begin
      load_bub = 1'b1;
      if (LOAD_USE_STALLS > 1) begin
        state_nxt = BUBBLE;
        cnt_nxt   = 3'(LOAD_USE_STALLS - 1);
      end
    end else if (state == BUBBLE) begin
      load_bub = 1'b1;
      cnt_nxt  = cnt - 3'd1;
      if (cnt == 3'd1) state_nxt = RUN;
    end else begin
      capture = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ID -> EX boundary; bubbles zero every field so forwarding can never match them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ex_q <= '0;
    else if (load_bub) ex_q <= '0;
    else if (capture)  ex_q <= id_bundle;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign ex_alu_op     = ex_q.alu_op;

`ifdef IDEX_PERF_CNT_EN
  logic bub_evt, flush_evt;
  assign bub_evt   = ~ex_stall & ~flush_ex & (((state == RUN) & hz) | (state == BUBBLE));
  assign flush_evt = ~ex_stall & flush_ex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubbles <= 32'd0;
      perf_flushes <= 32'd0;
    end else begin
      if (bub_evt)   perf_bubbles <= perf_bubbles + 32'd1;
      if (flush_evt) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`else
  assign perf_bubbles = 32'd0;
  assign perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: two instances (1 and 3 load-use bubbles) share one stimulus.
module tb_id_ex_stage_reg;
`ifdef IDEX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
  logic [3:0] id_alu_op;
  logic flush_ex, ex_stall;

  logic a_valid, a_rw, a_mr, a_mw, a_m2r, a_as, a_br, a_stall;
  logic [31:0] a_pc, a_d1, a_d2, a_imm, a_pb, a_pf;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [3:0] a_op;
  logic b_valid, b_rw, b_mr, b_mw, b_m2r, b_as, b_br, b_stall;
  logic [31:0] b_pc, b_d1, b_d2, b_imm, b_pb, b_pf;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic [3:0] b_op;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32), .LOAD_USE_STALLS(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_alu_op(id_alu_op), .flush_ex(flush_ex), .ex_stall(ex_stall),
    .ex_valid(a_valid), .ex_pc(a_pc), .ex_rs1_data(a_d1), .ex_rs2_data(a_d2), .ex_imm(a_imm),
    .ex_rs1(a_rs1), .ex_rs2(a_rs2), .ex_rd(a_rd), .ex_reg_write(a_rw), .ex_mem_read(a_mr),
    .ex_mem_write(a_mw), .ex_mem_to_reg(a_m2r), .ex_alu_src(a_as), .ex_branch(a_br),
    .ex_alu_op(a_op), .stall_id(a_stall), .perf_bubbles(a_pb), .perf_flushes(a_pf));

  id_ex_stage_reg #(.XLEN(32), .LOAD_USE_STALLS(3)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_alu_op(id_alu_op), .flush_ex(flush_ex), .ex_stall(ex_stall),
    .ex_valid(b_valid), .ex_pc(b_pc), .ex_rs1_data(b_d1), .ex_rs2_data(b_d2), .ex_imm(b_imm),
    .ex_rs1(b_rs1), .ex_rs2(b_rs2), .ex_rd(b_rd), .ex_reg_write(b_rw), .ex_mem_read(b_mr),
    .ex_mem_write(b_mw), .ex_mem_to_reg(b_m2r), .ex_alu_src(b_as), .ex_branch(b_br),
    .ex_alu_op(b_op), .stall_id(b_stall), .perf_bubbles(b_pb), .perf_flushes(b_pf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                       input logic mr);
    id_valid      = v;
    id_pc         = pc;
    id_rs1_data   = pc ^ 32'hA5A5_0000;
    id_rs2_data   = pc + 32'd1;
    id_imm        = pc + 32'd2;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_reg_write  = rw;
    id_mem_read   = mr;
    id_mem_write  = 1'b0;
    id_mem_to_reg = mr;
    id_alu_src    = mr;
    id_branch     = 1'b0;
    id_alu_op     = pc[5:2];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_ex = 1'b0;
    ex_stall = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (a_valid !== 1'b0 || a_pc !== 32'd0 || a_rd !== 5'd0 || a_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b pc=%h rd=%0d stall=%b, required 0", a_valid, a_pc, a_rd, a_stall);
    end
    // Put the 3-bubble instance into BUBBLE, then reset asynchronously between edges.
    drive(1'b1, 32'h10, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h14, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (b_valid !== 1'b0 || b_rd !== 5'd0 || b_mr !== 1'b0 || b_stall !== 1'b0 || b_pb !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_bubble: valid=%b rd=%0d mr=%b stall=%b pb=%0d, required all 0",
               b_valid, b_rd, b_mr, b_stall, b_pb);
    end
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (b_pc !== 32'h100 || b_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_first: pc=%h valid=%b, required 00000100 1", b_pc, b_valid);
    end
  endtask

  task automatic test_load_use();
    logic [3:0] s3;
    do_reset();
    drive(1'b1, 32'h10, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (a_mr !== 1'b1 || a_rd !== 5'd5 || a_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL lu_load_in_ex: mr=%b rd=%0d pc=%h, required 1 5 00000010", a_mr, a_rd, a_pc);
    end
    drive(1'b1, 32'h14, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0);
    #1;
    s3[0] = b_stall;
    n_checks++;
    if (a_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lu1_stall: got %b required 1", a_stall);
    end
    tick();
    n_checks++;
    if (a_valid !== 1'b0 || a_rd !== 5'd0 || a_rw !== 1'b0 || a_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL lu1_bubble: valid=%b rd=%0d rw=%b pc=%h, required 0", a_valid, a_rd, a_rw, a_pc);
    end
    s3[1] = b_stall;
    n_checks++;
    if (a_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lu1_stall_drop: got %b required 0", a_stall);
    end
    tick();
    n_checks++;
    if (a_pc !== 32'h14 || a_valid !== 1'b1 || a_rd !== 5'd7 || a_d2 !== 32'h15) begin
      n_fail++;
      $display("FAIL lu1_dep_enters: pc=%h valid=%b rd=%0d d2=%h, required 00000014 1 7 00000015",
               a_pc, a_valid, a_rd, a_d2);
    end
    s3[2] = b_stall;
    tick();
    s3[3] = b_stall;
    n_checks++;
    if (b_valid !== 1'b0 || b_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL lu3_third_bubble: valid=%b rd=%0d, required 0 0", b_valid, b_rd);
    end
    n_checks++;
    if (s3 !== 4'b0111) begin
      n_fail++;
      $display("FAIL lu3_stall_pattern: got %b required 0111", s3);
    end
    tick();
    n_checks++;
    if (b_pc !== 32'h14 || b_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lu3_dep_enters: pc=%h valid=%b, required 00000014 1", b_pc, b_valid);
    end
    n_checks++;
    if (b_pb !== (PERF ? 32'd3 : 32'd0) || a_pb !== (PERF ? 32'd1 : 32'd0)) begin
      n_fail++;
      $display("FAIL lu_perf_bubbles: b=%0d a=%0d, required %0d %0d", b_pb, a_pb,
               PERF ? 3 : 0, PERF ? 1 : 0);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    drive(1'b1, 32'h40, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h44, 5'd0, 5'd3, 5'd8, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (a_stall !== 1'b0 || b_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_no_stall: a=%b b=%b, required 0 0", a_stall, b_stall);
    end
    tick();
    n_checks++;
    if (b_pc !== 32'h44 || b_valid !== 1'b1 || b_rd !== 5'd8) begin
      n_fail++;
      $display("FAIL rd0_pass: pc=%h valid=%b rd=%0d, required 00000044 1 8", b_pc, b_valid, b_rd);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'h10, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h14, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0);
    tick();
    flush_ex = 1'b1;
    #1;
    n_checks++;
    if (b_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall_low: got %b required 0", b_stall);
    end
    tick();
    flush_ex = 1'b0;
    n_checks++;
    if (b_valid !== 1'b0 || a_valid !== 1'b0 || a_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_bubble: b_valid=%b a_valid=%b a_pc=%h, required 0 0 0", b_valid, a_valid, a_pc);
    end
    n_checks++;
    if (b_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_back_to_run: stall=%b required 0", b_stall);
    end
    tick();
    n_checks++;
    if (b_pc !== 32'h14 || b_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_resume: pc=%h valid=%b, required 00000014 1", b_pc, b_valid);
    end
    n_checks++;
    if (b_pf !== (PERF ? 32'd1 : 32'd0) || b_pb !== (PERF ? 32'd1 : 32'd0)) begin
      n_fail++;
      $display("FAIL flush_perf: pf=%0d pb=%0d, required %0d %0d", b_pf, b_pb, PERF ? 1 : 0, PERF ? 1 : 0);
    end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h204, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
    ex_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flush_ex = (i == 1 || i == 2);
      #1;
      n_checks++;
      if (a_stall !== 1'b1 || b_stall !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stall_c%0d: a=%b b=%b, required 1 1", i, a_stall, b_stall);
      end
      tick();
      n_checks++;
      if (a_pc !== 32'h200 || a_valid !== 1'b1 || a_rd !== 5'd3 || a_d1 !== 32'hA5A5_0200) begin
        n_fail++;
        $display("FAIL hold_frozen_c%0d: pc=%h valid=%b rd=%0d d1=%h, required 00000200 1 3 a5a50200",
                 i, a_pc, a_valid, a_rd, a_d1);
      end
    end
    ex_stall = 1'b0;
    flush_ex = 1'b0;
    tick();
    n_checks++;
    if (a_pc !== 32'h204 || a_rd !== 5'd6 || a_pf !== 32'd0) begin
      n_fail++;
      $display("FAIL hold_release: pc=%h rd=%0d pf=%0d, required 00000204 6 0", a_pc, a_rd, a_pf);
    end
  endtask

  task automatic test_invalid_passthrough();
    do_reset();
    drive(1'b1, 32'h300, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h304, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (a_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_no_hazard: stall=%b required 0", a_stall);
    end
    tick();
    n_checks++;
    if (a_valid !== 1'b0 || a_rw !== 1'b1 || a_rd !== 5'd9 || a_pc !== 32'h304) begin
      n_fail++;
      $display("FAIL invalid_capture: valid=%b rw=%b rd=%0d pc=%h, required 0 1 9 00000304",
               a_valid, a_rw, a_rd, a_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h404, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (a_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_stall: got %b required 1", a_stall);
    end
    tick();
    tick();
    n_checks++;
    if (a_pc !== 32'h404 || a_mr !== 1'b1 || a_rd !== 5'd6) begin
      n_fail++;
      $display("FAIL b2b_second_load: pc=%h mr=%b rd=%0d, required 00000404 1 6", a_pc, a_mr, a_rd);
    end
    drive(1'b1, 32'h408, 5'd7, 5'd6, 5'd8, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (a_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_stall: got %b required 1", a_stall);
    end
    tick();
    n_checks++;
    if (a_valid !== 1'b0 || a_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_single_bubble: valid=%b stall=%b, required 0 0", a_valid, a_stall);
    end
    tick();
    n_checks++;
    if (a_pc !== 32'h408 || a_pb !== (PERF ? 32'd2 : 32'd0)) begin
      n_fail++;
      $display("FAIL b2b_dep_enters: pc=%h pb=%0d, required 00000408 %0d", a_pc, a_pb, PERF ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_flush();
    test_hold();
    test_invalid_passthrough();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
